pe_inst_seq: RTL

Instruction sequencer directly upstream of `PE_control`. It accepts one layer descriptor from the top controller and expands it into the ordered PE instruction stream: SET, LOAD_WGHT, then LOAD_IFMAP/CONV per ifmap row, then an optional ACC. It presents that stream on the `opcode`/`conv_info`/valid/ready instruction port of `PE_control`. It signals completion or a descriptor error back to the top controller.

---
 rtl/pe_inst_seq_if.sv | 28 ++
 rtl/pe_inst_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pe_inst_seq_if.sv
// Instruction port between pe_inst_seq (master) and PE_control (slave).
// valid/ready handshake carrying opcode, conv_info and the current row pass.
interface pe_inst_seq_if #(
    parameter int CONV_INFO_BITWIDTH = 9,
    parameter int ROW_CNT_BITWIDTH   = 4
);
    logic [2:0]                    opcode;
    logic [CONV_INFO_BITWIDTH-1:0] conv_info;
    logic                          inst_valid;
    logic                          inst_ready;
    logic [ROW_CNT_BITWIDTH-1:0]   row_idx;

    modport master (
        output opcode,
        output conv_info,
        output inst_valid,
        output row_idx,
        input  inst_ready
    );

    modport slave (
        input  opcode,
        input  conv_info,
        input  inst_valid,
        input  row_idx,
        output inst_ready
    );
endinterface

// File: rtl/pe_inst_seq.sv
// pe_inst_seq: expands one layer descriptor into the PE instruction stream.
// Define PE_INST_SEQ_PERF_EN to add the o_stall_cycles counter.
module pe_inst_seq #(
    parameter int CONV_INFO_BITWIDTH = 9,
    parameter int ROW_CNT_BITWIDTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_desc_valid,
    output logic                          o_desc_ready,
    input  logic [CONV_INFO_BITWIDTH-1:0] i_desc_conv_info,
    input  logic [ROW_CNT_BITWIDTH-1:0]   i_desc_rows,
    input  logic                          i_desc_acc,
    pe_inst_seq_if.master                 inst,
    output logic                          o_done,
    output logic                          o_err
`ifdef PE_INST_SEQ_PERF_EN
    ,
    output logic [15:0]                   o_stall_cycles
`endif
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_WGHT,
        S_IFMAP,
        S_CONV,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_IFMAP = 3'b010;
    localparam logic [2:0] OP_WGHT  = 3'b011;
    localparam logic [2:0] OP_CONV  = 3'b100;
    localparam logic [2:0] OP_ACC   = 3'b101;

    localparam logic [ROW_CNT_BITWIDTH-1:0] ROW_ONE = 1;

    state_t                        state_q, state_d;
    logic [CONV_INFO_BITWIDTH-1:0] ci_q;
    logic [ROW_CNT_BITWIDTH-1:0]   rows_q;
    logic [ROW_CNT_BITWIDTH-1:0]   row_q;
    logic                          acc_q;
    logic                          err_q, err_d;
    logic                          desc_hs, bad, fire, last;
    logic                          valid_d;
    logic [2:0]                    opc_d;

    assign desc_hs = o_desc_ready && i_desc_valid;
    assign fire    = inst.inst_valid && inst.inst_ready;
    assign last    = (row_q == rows_q - ROW_ONE);
    assign bad     = (i_desc_conv_info[8:6] == 3'd0)
                  || (i_desc_conv_info[5:3] == 3'd0)
                  || (i_desc_conv_info[2:0] == 3'd0)
                  || (i_desc_rows == '0);

    assign inst.conv_info = ci_q;
    assign inst.row_idx   = row_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (desc_hs) begin
                    state_d = bad ? S_DONE : S_SET;
                    err_d   = bad;
                end
            end
            S_SET:   if (fire) state_d = S_WGHT;
            S_WGHT:  if (fire) state_d = S_IFMAP;
            S_IFMAP: if (fire) state_d = S_CONV;
            S_CONV: begin
                if (fire) begin
                    if (last) state_d = acc_q ? S_ACC : S_DONE;
                    else      state_d = S_IFMAP;
                end
            end
            S_ACC:   if (fire) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned
    always_comb begin
        opc_d   = OP_NOP;
        valid_d = 1'b1;
        unique case (1'b1)
            state_d == S_SET:   opc_d = OP_SET;
            state_d == S_WGHT:  opc_d = OP_WGHT;
            state_d == S_IFMAP: opc_d = OP_IFMAP;
            state_d == S_CONV:  opc_d = OP_CONV;
            state_d == S_ACC:   opc_d = OP_ACC;
            default:            valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= S_IDLE;
            err_q           <= 1'b0;
            ci_q            <= '0;
            rows_q          <= '0;
            row_q           <= '0;
            acc_q           <= 1'b0;
            inst.opcode     <= OP_NOP;
            inst.inst_valid <= 1'b0;
            o_desc_ready    <= 1'b0;
            o_done          <= 1'b0;
            o_err           <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            inst.opcode     <= opc_d;
            inst.inst_valid <= valid_d;
            o_desc_ready    <= (state_d == S_IDLE);
            o_done          <= (state_d == S_DONE) && !err_d;
            o_err           <= (state_d == S_DONE) && err_d;
            if (desc_hs) begin
                ci_q   <= i_desc_conv_info;
                rows_q <= i_desc_rows;
                acc_q  <= i_desc_acc;
                row_q  <= '0;
            end else if ((state_q == S_CONV) && fire && !last) begin
                row_q  <= row_q + ROW_ONE;
            end
        end
    end

`ifdef PE_INST_SEQ_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else if (desc_hs) begin
            stall_q <= '0;
        end else if (inst.inst_valid && !inst.inst_ready
                     && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cycles = stall_q;
`endif
endmodule
